tap_loader: RTL and testbench

Streaming Oric TAP parser that sits directly upstream of the 64 KB system RAM write port B. It consumes the HPS download byte stream, validates the sync/header/name preamble, and writes the program body into RAM at its header start address. It absorbs port-B write loss under CPU (port A) contention by holding each write until accepted, and reports load addresses and autorun flags to the machine-control logic.

---
 rtl/oric_pkg.sv | 21 ++
 rtl/tap_loader_if.sv | 33 +++
 rtl/tap_wr_hold.sv | 37 +++
 rtl/tap_loader.sv | 233 +++++++++++++++++++++++
 tb/tb_tap_loader.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oric_pkg.sv
// Shared types and constants for the Oric TAP stream loader.
package oric_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SYNC,
      ST_HDR,
      ST_NAME,
      ST_DATA,
      ST_DONE,
      ST_ERROR
   } tap_state_t;

   localparam logic [7:0] TAP_SYNC_BYTE = 8'h16;
   localparam logic [7:0] TAP_MARK_BYTE = 8'h24;
   localparam logic [7:0] TAP_MCODE     = 8'h80;
   localparam int         TAP_HDR_LEN   = 9;
   localparam int         TAP_NAME_MAX  = 16;

endpackage

// File: rtl/tap_loader_if.sv
// Download stream, RAM port-B write bus and load status of the TAP loader.
interface tap_loader_if;

   logic        dl_active;
   logic        dl_wr;
   logic [7:0]  dl_data;
   logic        dl_wait;
   logic        port_a_busy;
   logic [15:0] ram_ad_b;
   logic [7:0]  ram_d_b;
   logic        ram_we_b;
   logic [15:0] start_addr;
   logic [15:0] end_addr;
   logic        autorun;
   logic        mcode;
   logic        load_done;
   logic        load_err;

   // loader side
   modport slave (
      input  dl_active, dl_wr, dl_data, port_a_busy,
      output dl_wait, ram_ad_b, ram_d_b, ram_we_b,
      output start_addr, end_addr, autorun, mcode, load_done, load_err
   );

   // download source / RAM / machine-control side
   modport master (
      output dl_active, dl_wr, dl_data, port_a_busy,
      input  dl_wait, ram_ad_b, ram_d_b, ram_we_b,
      input  start_addr, end_addr, autorun, mcode, load_done, load_err
   );

endinterface

// File: rtl/tap_wr_hold.sv
// Single-entry port-B write holding register. A loaded write stays on the
// bus until a cycle where port A is idle; that cycle is the accepted write.
// A new write may be loaded in the same cycle the current one is accepted.
module tap_wr_hold (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        flush,
   input  logic        load,
   input  logic [15:0] load_addr,
   input  logic [7:0]  load_data,
   input  logic        busy,
   output logic        we,
   output logic [15:0] addr,
   output logic [7:0]  data,
   output logic        accept
);

   assign accept = we & ~busy;

   // hold address/data/enable until port A leaves the RAM free
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         we   <= 1'b0;
         addr <= 16'h0000;
         data <= 8'h00;
      end else if (load) begin
         we   <= 1'b1;
         addr <= load_addr;
         data <= load_data;
      end else if (flush) begin
         we   <= 1'b0;
      end else if (accept) begin
         we   <= 1'b0;
      end
   end

endmodule

// File: rtl/tap_loader.sv
// Oric TAP stream parser feeding RAM port B.
// Optional RAM clear before parsing is built when TAP_CLEAR_EN is defined.
//
// state    | meaning
// IDLE     | after reset, waiting for first download
// CLEAR    | sweeping CLR_START..CLR_END with zeros (TAP_CLEAR_EN only)
// SYNC     | counting 0x16 bytes, waiting for 0x24 marker
// HDR      | collecting header bytes H0..H8
// NAME     | skipping zero-terminated program name
// DATA     | writing body bytes from start_addr to end_addr
// DONE     | body fully written
// ERROR    | malformed, truncated or aborted stream
module tap_loader
   import oric_pkg::*;
#(
`ifdef TAP_CLEAR_EN
   parameter logic [15:0] CLR_START = 16'h0000,
   parameter logic [15:0] CLR_END   = 16'hFFFF,
`endif
   parameter int unsigned SYNC_MIN  = 3
) (
   input  logic        clk_sys,
   input  logic        reset,
   tap_loader_if.slave bus
);

   localparam logic [3:0] SYNC_MIN_C = 4'(SYNC_MIN);
   localparam logic [3:0] HDR_LAST   = 4'(TAP_HDR_LEN - 1);
   localparam logic [4:0] NAME_MAX_C = 5'(TAP_NAME_MAX);

   tap_state_t  state;
   logic        dl_active_q;
   logic        act_rise;
   logic        act_fall;
   logic        abort;
   logic [3:0]  sync_cnt;
   logic [3:0]  hdr_idx;
   logic [4:0]  name_cnt;
   logic [15:0] cur_addr;
   logic [15:0] start_addr;
   logic [15:0] end_addr;
   logic        autorun;
   logic        mcode;
   logic        load_done;
   logic        load_err;

   logic        hold_load;
   logic        hold_flush;
   logic [15:0] hold_ad_in;
   logic [7:0]  hold_d_in;
   logic        hold_we;
   logic        hold_accept;
   logic [15:0] hold_ad;
   logic [7:0]  hold_d;

`ifdef TAP_CLEAR_EN
   logic [15:0] clr_addr;
`endif

   assign act_rise = bus.dl_active & ~dl_active_q;
   assign act_fall = ~bus.dl_active & dl_active_q;
   assign abort    = act_fall & (state inside {ST_CLEAR, ST_SYNC, ST_HDR, ST_NAME, ST_DATA});

   // choose what, if anything, enters the write holding register this cycle
   always_comb begin
      hold_flush = act_rise;
      hold_load  = 1'b0;
      hold_ad_in = cur_addr;
      hold_d_in  = bus.dl_data;
      if (act_rise) begin
`ifdef TAP_CLEAR_EN
         hold_load  = 1'b1;
         hold_ad_in = CLR_START;
         hold_d_in  = 8'h00;
`endif
      end else if (!abort) begin
         case (state)
            ST_DATA: begin
               if (bus.dl_wr && (!hold_we || hold_accept))
                  hold_load = 1'b1;
            end
`ifdef TAP_CLEAR_EN
            ST_CLEAR: begin
               if (hold_accept && (hold_ad != CLR_END)) begin
                  hold_load  = 1'b1;
                  hold_ad_in = clr_addr;
                  hold_d_in  = 8'h00;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   tap_wr_hold u_hold (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .flush     (hold_flush),
      .load      (hold_load),
      .load_addr (hold_ad_in),
      .load_data (hold_d_in),
      .busy      (bus.port_a_busy),
      .we        (hold_we),
      .addr      (hold_ad),
      .data      (hold_d),
      .accept    (hold_accept)
   );

   // parser state machine and registered load status
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         dl_active_q <= 1'b0;
         sync_cnt    <= 4'd0;
         hdr_idx     <= 4'd0;
         name_cnt    <= 5'd0;
         cur_addr    <= 16'h0000;
         start_addr  <= 16'h0000;
         end_addr    <= 16'h0000;
         autorun     <= 1'b0;
         mcode       <= 1'b0;
         load_done   <= 1'b0;
         load_err    <= 1'b0;
`ifdef TAP_CLEAR_EN
         clr_addr    <= 16'h0000;
`endif
      end else begin
         dl_active_q <= bus.dl_active;
         if (act_rise) begin
            sync_cnt   <= 4'd0;
            hdr_idx    <= 4'd0;
            name_cnt   <= 5'd0;
            start_addr <= 16'h0000;
            end_addr   <= 16'h0000;
            autorun    <= 1'b0;
            mcode      <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef TAP_CLEAR_EN
            clr_addr   <= CLR_START + 16'd1;
            state      <= ST_CLEAR;
`else
            state      <= ST_SYNC;
`endif
         end else if (abort) begin
            state    <= ST_ERROR;
            load_err <= 1'b1;
         end else begin
            case (state)
`ifdef TAP_CLEAR_EN
               ST_CLEAR: begin
                  if (hold_load)
                     clr_addr <= clr_addr + 16'd1;
                  if (hold_accept && (hold_ad == CLR_END))
                     state <= ST_SYNC;
               end
`endif
               ST_SYNC: begin
                  if (bus.dl_wr) begin
                     if (bus.dl_data == TAP_SYNC_BYTE) begin
                        if (sync_cnt != 4'd15)
                           sync_cnt <= sync_cnt + 4'd1;
                     end else if ((bus.dl_data == TAP_MARK_BYTE) && (sync_cnt >= SYNC_MIN_C)) begin
                        hdr_idx <= 4'd0;
                        state   <= ST_HDR;
                     end else begin
                        sync_cnt <= 4'd0;
                     end
                  end
               end
               ST_HDR: begin
                  if (bus.dl_wr) begin
                     hdr_idx <= hdr_idx + 4'd1;
                     case (hdr_idx)
                        4'd2: mcode            <= (bus.dl_data == TAP_MCODE);
                        4'd3: autorun          <= (bus.dl_data != 8'h00);
                        4'd4: end_addr[15:8]   <= bus.dl_data;
                        4'd5: end_addr[7:0]    <= bus.dl_data;
                        4'd6: start_addr[15:8] <= bus.dl_data;
                        4'd7: start_addr[7:0]  <= bus.dl_data;
                        default: ;
                     endcase
                     if (hdr_idx == HDR_LAST) begin
                        if (end_addr < start_addr) begin
                           state    <= ST_ERROR;
                           load_err <= 1'b1;
                        end else begin
                           name_cnt <= 5'd0;
                           cur_addr <= start_addr;
                           state    <= ST_NAME;
                        end
                     end
                  end
               end
               ST_NAME: begin
                  if (bus.dl_wr) begin
                     if (bus.dl_data == 8'h00) begin
                        state <= ST_DATA;
                     end else if (name_cnt == NAME_MAX_C) begin
                        state    <= ST_ERROR;
                        load_err <= 1'b1;
                     end else begin
                        name_cnt <= name_cnt + 5'd1;
                     end
                  end
               end
               ST_DATA: begin
                  if (hold_load)
                     cur_addr <= cur_addr + 16'd1;
                  if (hold_accept && (hold_ad == end_addr)) begin
                     state     <= ST_DONE;
                     load_done <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.ram_we_b   = hold_we;
   assign bus.ram_ad_b   = hold_ad;
   assign bus.ram_d_b    = hold_d;
   assign bus.dl_wait    = hold_we | (state == ST_CLEAR);
   assign bus.start_addr = start_addr;
   assign bus.end_addr   = end_addr;
   assign bus.autorun    = autorun;
   assign bus.mcode      = mcode;
   assign bus.load_done  = load_done;
   assign bus.load_err   = load_err;

endmodule

// File: tb/tb_tap_loader.sv
// Bench for tap_loader: directed scenarios plus randomized TAP streams
// compared against an index-based model of the TAP format.
module tb_tap_loader;

   localparam int SYNC_MIN = 3;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   always #5 clk_sys = ~clk_sys;

   tap_loader_if bus ();

`ifdef TAP_CLEAR_EN
   tap_loader #(.CLR_START(16'h0400), .CLR_END(16'h040F)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );
`else
   tap_loader dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );
`endif

   int   n_checks = 0;
   int   n_pass   = 0;
   int   wr_count = 0;
   int   wr_base  = 0;
   logic [7:0] ram [0:65535];

   bit   rand_busy  = 1'b0;
   int   busy_pct   = 30;
   logic busy_force = 1'b0;
   logic busy_rnd   = 1'b0;

   // port A contention: either random or forced by a directed test
   always @(negedge clk_sys) busy_rnd = ($urandom_range(0, 99) < busy_pct);
   assign bus.port_a_busy = rand_busy ? busy_rnd : busy_force;

   // RAM port B: a write lands only when port A is idle
   always @(posedge clk_sys) begin
      if (bus.ram_we_b && !bus.port_a_busy) begin
         ram[bus.ram_ad_b] <= bus.ram_d_b;
         wr_count <= wr_count + 1;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      while (bus.dl_wait === 1'b1 && guard < 200) begin
         @(negedge clk_sys);
         guard++;
      end
      if (guard >= 200) begin
         n_checks++;
         $display("FAIL send_wait: dl_wait stayed 1 for 200 cycles, required 0");
      end
      bus.dl_wr   = 1'b1;
      bus.dl_data = b;
      @(negedge clk_sys);
      bus.dl_wr   = 1'b0;
   endtask

   task automatic send_range(input logic [7:0] s[$], input int from, input int to_excl);
      for (int i = from; i < to_excl; i++) send_byte(s[i]);
   endtask

   task automatic wait_no_wait();
      int guard = 0;
      while (bus.dl_wait === 1'b1 && guard < 2000) begin
         @(negedge clk_sys);
         guard++;
      end
      if (guard >= 2000) begin
         n_checks++;
         $display("FAIL wait_idle: dl_wait stayed 1 for 2000 cycles, required 0");
      end
   endtask

   task automatic start_load(output int wait_cycles);
      bus.dl_active = 1'b1;
      @(negedge clk_sys);
      wait_cycles = 0;
      while (bus.dl_wait === 1'b1 && wait_cycles < 2000) begin
         wait_cycles++;
         @(negedge clk_sys);
      end
      if (wait_cycles >= 2000) begin
         n_checks++;
         $display("FAIL start_wait: dl_wait stayed 1 after dl_active rise, required 0");
      end
      wr_base = wr_count;
   endtask

   task automatic end_load();
      wait_no_wait();
      repeat (2) @(negedge clk_sys);
      bus.dl_active = 1'b0;
      repeat (2) @(negedge clk_sys);
   endtask

   // sync x3, marker, header, name of name_len letters, terminator, data
   task automatic make_stream(input logic [15:0] st, input logic [15:0] en,
                              input logic [7:0] h2, input logic [7:0] h3,
                              input int name_len, input logic [7:0] d[$],
                              output logic [7:0] s[$]);
      s = {};
      repeat (3) s.push_back(8'h16);
      s.push_back(8'h24);
      s.push_back(8'h00); s.push_back(8'h00); s.push_back(h2); s.push_back(h3);
      s.push_back(en[15:8]); s.push_back(en[7:0]);
      s.push_back(st[15:8]); s.push_back(st[7:0]);
      s.push_back(8'h00);
      for (int i = 0; i < name_len; i++) s.push_back(8'h41 + 8'(i));
      s.push_back(8'h00);
      foreach (d[i]) s.push_back(d[i]);
   endtask

   // expected outcome of a complete download of stream s
   task automatic model(input logic [7:0] s[$], output bit e_done, output bit e_err,
                        output logic [15:0] e_st, output logic [15:0] e_en,
                        output bit e_mc, output bit e_ar, output int e_nwr, output int e_dpos);
      int p = -1;
      int q;
      int nz;
      int n;
      int avail;
      bit ok;
      e_done = 0; e_err = 0; e_st = 0; e_en = 0; e_mc = 0; e_ar = 0; e_nwr = 0; e_dpos = 0;
      for (int i = SYNC_MIN; i < s.size() && p < 0; i++) begin
         if (s[i] == 8'h24) begin
            ok = 1;
            for (int k = 1; k <= SYNC_MIN; k++) if (s[i-k] != 8'h16) ok = 0;
            if (ok) p = i;
         end
      end
      if (p < 0 || p + 9 >= s.size()) begin e_err = 1; return; end
      e_mc = (s[p+3] == 8'h80);
      e_ar = (s[p+4] != 8'h00);
      e_en = {s[p+5], s[p+6]};
      e_st = {s[p+7], s[p+8]};
      if (e_en < e_st) begin e_err = 1; return; end
      q  = p + 10;
      nz = 0;
      forever begin
         if (q >= s.size()) begin e_err = 1; return; end
         if (s[q] == 8'h00) break;
         nz++;
         if (nz > 16) begin e_err = 1; return; end
         q++;
      end
      e_dpos = q + 1;
      n      = int'(e_en) - int'(e_st) + 1;
      avail  = s.size() - e_dpos;
      e_nwr  = (avail < n) ? avail : n;
      if (avail >= n) e_done = 1; else e_err = 1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_sys);
      n_checks++;
      if ({bus.ram_we_b, bus.dl_wait, bus.load_done, bus.load_err, bus.autorun, bus.mcode} !== 6'b0)
         $display("FAIL reset_flags: got %b, required 000000",
                  {bus.ram_we_b, bus.dl_wait, bus.load_done, bus.load_err, bus.autorun, bus.mcode});
      else n_pass++;
      reset = 1'b0;
      repeat (2) @(negedge clk_sys);
      n_checks++;
      if ({bus.start_addr, bus.end_addr} !== 32'h0)
         $display("FAIL reset_addr: got %h/%h, required 0000/0000", bus.start_addr, bus.end_addr);
      else n_pass++;
      n_checks++;
      if ({bus.ram_we_b, bus.dl_wait, bus.load_done, bus.load_err} !== 4'b0)
         $display("FAIL post_reset_flags: got %b, required 0000",
                  {bus.ram_we_b, bus.dl_wait, bus.load_done, bus.load_err});
      else n_pass++;
   endtask

   task automatic test_basic();
      logic [7:0] d[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [7:0] s[$];
      int wc;
      make_stream(16'h0500, 16'h0503, 8'h80, 8'hC7, 2, d, s);
      start_load(wc);
      send_range(s, 0, s.size());
      end_load();
      n_checks++;
      if ({bus.load_done, bus.load_err, bus.mcode, bus.autorun} !== 4'b1011)
         $display("FAIL basic_flags: done/err/mcode/autorun=%b, required 1011",
                  {bus.load_done, bus.load_err, bus.mcode, bus.autorun});
      else n_pass++;
      n_checks++;
      if (bus.start_addr !== 16'h0500 || bus.end_addr !== 16'h0503)
         $display("FAIL basic_addr: got %h..%h, required 0500..0503", bus.start_addr, bus.end_addr);
      else n_pass++;
      n_checks++;
      if ({ram[16'h0500], ram[16'h0501], ram[16'h0502], ram[16'h0503]} !== 32'h11223344)
         $display("FAIL basic_ram: got %h%h%h%h, required 11223344",
                  ram[16'h0500], ram[16'h0501], ram[16'h0502], ram[16'h0503]);
      else n_pass++;
      n_checks++;
      if (wr_count - wr_base !== 4)
         $display("FAIL basic_wrcount: got %0d, required 4", wr_count - wr_base);
      else n_pass++;
   endtask

   task automatic test_busy();
      logic [7:0] d[$] = '{8'h55, 8'h66, 8'h77, 8'h88};
      logic [7:0] s[$];
      int wc;
      int held = 0;
      bit stable = 1;
      bit waith = 1;
      make_stream(16'h0500, 16'h0503, 8'h00, 8'h00, 2, d, s);
      start_load(wc);
      send_range(s, 0, s.size() - 4);
      send_byte(8'h55);
      n_checks++;
      if (bus.ram_we_b !== 1'b1 || bus.ram_ad_b !== 16'h0500 || bus.ram_d_b !== 8'h55)
         $display("FAIL busy_latency: we/ad/d=%b/%h/%h, required 1/0500/55",
                  bus.ram_we_b, bus.ram_ad_b, bus.ram_d_b);
      else n_pass++;
      @(negedge clk_sys);
      n_checks++;
      if (bus.ram_we_b !== 1'b0)
         $display("FAIL busy_accept: we=%b one cycle after write, required 0", bus.ram_we_b);
      else n_pass++;
      send_byte(8'h66);
      for (int i = 0; i < 8; i++) begin
         if (bus.ram_we_b === 1'b1) begin
            held++;
            if (bus.ram_ad_b !== 16'h0501 || bus.ram_d_b !== 8'h66) stable = 0;
            if (bus.dl_wait !== 1'b1) waith = 0;
         end
         busy_force = (i < 3);
         @(negedge clk_sys);
      end
      busy_force = 1'b0;
      n_checks++;
      if (held !== 4) $display("FAIL busy_held: we high %0d cycles, required 4", held);
      else n_pass++;
      n_checks++;
      if (!(stable && waith))
         $display("FAIL busy_stable: stable=%0d dl_wait_high=%0d, required 1/1", stable, waith);
      else n_pass++;
      send_byte(8'h77);
      send_byte(8'h88);
      end_load();
      n_checks++;
      if ({ram[16'h0500], ram[16'h0501], ram[16'h0502], ram[16'h0503]} !== 32'h55667788 ||
          bus.load_done !== 1'b1)
         $display("FAIL busy_ram: got %h%h%h%h done=%b, required 55667788 done=1",
                  ram[16'h0500], ram[16'h0501], ram[16'h0502], ram[16'h0503], bus.load_done);
      else n_pass++;
   endtask

   task automatic test_resync();
      logic [7:0] d[$] = '{8'hA1, 8'hB2};
      logic [7:0] s[$];
      logic [7:0] pre[$] = '{8'h16, 8'h16, 8'h24};
      int wc;
      make_stream(16'h0700, 16'h0701, 8'h00, 8'h01, 1, d, s);
      s = {pre, s};
      start_load(wc);
      send_range(s, 0, s.size());
      end_load();
      n_checks++;
      if ({bus.load_done, bus.load_err, bus.autorun, bus.mcode} !== 4'b1010 ||
          bus.start_addr !== 16'h0700 || bus.end_addr !== 16'h0701)
         $display("FAIL resync_status: done/err/ar/mc=%b start=%h end=%h, required 1010 0700 0701",
                  {bus.load_done, bus.load_err, bus.autorun, bus.mcode}, bus.start_addr, bus.end_addr);
      else n_pass++;
      n_checks++;
      if ({ram[16'h0700], ram[16'h0701]} !== 16'hA1B2 || wr_count - wr_base !== 2)
         $display("FAIL resync_ram: got %h%h writes=%0d, required A1B2 writes=2",
                  ram[16'h0700], ram[16'h0701], wr_count - wr_base);
      else n_pass++;
   endtask

   task automatic test_bad_range();
      logic [7:0] d[$] = '{8'h01, 8'h02, 8'h03};
      logic [7:0] s[$];
      int wc;
      make_stream(16'h0600, 16'h05FF, 8'h00, 8'h00, 1, d, s);
      start_load(wc);
      send_range(s, 0, 12);
      n_checks++;
      if (bus.load_err !== 1'b0 || bus.start_addr !== 16'h0600 || bus.end_addr !== 16'h05FF)
         $display("FAIL badrange_pre: err=%b start=%h end=%h before H8, required 0 0600 05FF",
                  bus.load_err, bus.start_addr, bus.end_addr);
      else n_pass++;
      send_byte(s[12]);
      n_checks++;
      if (bus.load_err !== 1'b1)
         $display("FAIL badrange_err: load_err=%b after H8, required 1", bus.load_err);
      else n_pass++;
      send_range(s, 13, s.size());
      end_load();
      n_checks++;
      if (wr_count - wr_base !== 0 || bus.load_done !== 1'b0 || bus.load_err !== 1'b1)
         $display("FAIL badrange_writes: writes=%0d done=%b err=%b, required 0 0 1",
                  wr_count - wr_base, bus.load_done, bus.load_err);
      else n_pass++;
   endtask

   task automatic test_abort();
      logic [7:0] d[$] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      logic [7:0] s[$];
      int wc;
      make_stream(16'h0900, 16'h0903, 8'h00, 8'h00, 2, d, s);
      start_load(wc);
      send_range(s, 0, s.size() - 2);
      end_load();
      n_checks++;
      if (bus.load_err !== 1'b1 || bus.load_done !== 1'b0)
         $display("FAIL abort_flags: err=%b done=%b, required 1 0", bus.load_err, bus.load_done);
      else n_pass++;
      n_checks++;
      if (wr_count - wr_base !== 2 || {ram[16'h0900], ram[16'h0901]} !== 16'hC1C2)
         $display("FAIL abort_ram: writes=%0d ram=%h%h, required 2 C1C2",
                  wr_count - wr_base, ram[16'h0900], ram[16'h0901]);
      else n_pass++;
   endtask

`ifdef TAP_CLEAR_EN
   task automatic test_clear();
      logic [7:0] ff[$];
      logic [7:0] d[$] = '{8'h5A};
      logic [7:0] s[$];
      int wc;
      int w_before;
      int bad = 0;
      for (int i = 0; i < 16; i++) ff.push_back(8'hFF);
      make_stream(16'h0400, 16'h040F, 8'h00, 8'h00, 1, ff, s);
      start_load(wc);
      send_range(s, 0, s.size());
      end_load();
      for (int a = 16'h0400; a <= 16'h040F; a++) if (ram[a] !== 8'hFF) bad++;
      n_checks++;
      if (bad !== 0 || bus.load_done !== 1'b1)
         $display("FAIL clear_preload: %0d bytes not FF, done=%b, required 0 1", bad, bus.load_done);
      else n_pass++;
      w_before = wr_count;
      make_stream(16'h0500, 16'h0500, 8'h00, 8'h00, 0, d, s);
      start_load(wc);
      n_checks++;
      if (wc !== 16) $display("FAIL clear_wait: dl_wait high %0d cycles, required 16", wc);
      else n_pass++;
      bad = 0;
      for (int a = 16'h0400; a <= 16'h040F; a++) if (ram[a] !== 8'h00) bad++;
      n_checks++;
      if (bad !== 0 || wr_base - w_before !== 16)
         $display("FAIL clear_ram: %0d nonzero bytes, %0d clear writes, required 0 16",
                  bad, wr_base - w_before);
      else n_pass++;
      send_range(s, 0, s.size());
      end_load();
      n_checks++;
      if (bus.load_done !== 1'b1 || ram[16'h0500] !== 8'h5A)
         $display("FAIL clear_parse: done=%b ram=%h, required 1 5A", bus.load_done, ram[16'h0500]);
      else n_pass++;
   endtask
`endif

   task automatic test_random();
      logic [7:0] s[$];
      logic [7:0] body[$];
      logic [7:0] d[$];
      logic [15:0] st, en, tmp;
      bit e_done, e_err, e_mc, e_ar;
      logic [15:0] e_st, e_en;
      int e_nwr, e_dpos, wc, nd, bad;
      logic [7:0] b;
      rand_busy = 1'b1;
      for (int it = 0; it < 20; it++) begin
         s = {};
         d = {};
         repeat ($urandom_range(0, 4)) begin
            if ($urandom_range(0, 1) == 1) begin
               repeat ($urandom_range(1, 2)) s.push_back(8'h16);
               s.push_back(8'h24);
            end else begin
               b = 8'($urandom_range(0, 255));
               if (b == 8'h16) b = 8'h17;
               s.push_back(b);
            end
         end
         repeat ($urandom_range(0, 3)) s.push_back(8'h16);
         nd = $urandom_range(1, 12);
         for (int i = 0; i < nd; i++) d.push_back(8'($urandom_range(0, 255)));
         st = 16'h1000 + 16'($urandom_range(0, 16'h6000));
         en = st + 16'(nd - 1);
         if ($urandom_range(0, 9) == 0 && nd > 1) begin tmp = st; st = en; en = tmp; end
         make_stream(st, en, ($urandom_range(0, 1) == 1) ? 8'h80 : 8'($urandom_range(0, 127)),
                     8'($urandom_range(0, 3)), $urandom_range(0, 17), d, body);
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, nd)) void'(body.pop_back());
         s = {s, body};
         model(s, e_done, e_err, e_st, e_en, e_mc, e_ar, e_nwr, e_dpos);
         start_load(wc);
         send_range(s, 0, s.size());
         end_load();
         n_checks++;
         if ({bus.load_done, bus.load_err} !== {e_done, e_err})
            $display("FAIL rand%0d_status: done/err=%b%b, required %b%b",
                     it, bus.load_done, bus.load_err, e_done, e_err);
         else n_pass++;
         n_checks++;
         if (bus.start_addr !== e_st || bus.end_addr !== e_en)
            $display("FAIL rand%0d_addr: %h..%h, required %h..%h",
                     it, bus.start_addr, bus.end_addr, e_st, e_en);
         else n_pass++;
         n_checks++;
         if ({bus.mcode, bus.autorun} !== {e_mc, e_ar})
            $display("FAIL rand%0d_hdrflags: mcode/autorun=%b%b, required %b%b",
                     it, bus.mcode, bus.autorun, e_mc, e_ar);
         else n_pass++;
         n_checks++;
         if (wr_count - wr_base !== e_nwr)
            $display("FAIL rand%0d_writes: %0d, required %0d", it, wr_count - wr_base, e_nwr);
         else n_pass++;
         bad = 0;
         for (int i = 0; i < e_nwr; i++)
            if (ram[16'(int'(e_st) + i)] !== s[e_dpos + i]) bad++;
         n_checks++;
         if (bad !== 0) $display("FAIL rand%0d_ram: %0d wrong bytes, required 0", it, bad);
         else n_pass++;
      end
      rand_busy = 1'b0;
   endtask

   initial begin
      bus.dl_active = 1'b0;
      bus.dl_wr     = 1'b0;
      bus.dl_data   = 8'h00;
      test_reset();
      test_basic();
      test_busy();
      test_resync();
      test_bad_range();
      test_abort();
`ifdef TAP_CLEAR_EN
      test_clear();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
